rs_ex_muldiv: RTL and testbench

Multi-cycle execution unit for the RV32M multiply/divide group, sitting beside the single-cycle ALU execution unit behind the reservation station and broadcasting on the common data bus. It accepts one operation at a time with its ROB tag, computes products iteratively or in one registered cycle and quotients/remainders with a radix-2 restoring divider, and emits a single-cycle result pulse. Width and tag size are parameters; flush and the global `rdy` stall are honoured in every state.

---
 rtl/rs_ex_muldiv.sv | 229 ++++++++++++++++++++++
 tb/tb_rs_ex_muldiv.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_ex_muldiv.sv
// rs_ex_muldiv: RV32M multiply/divide execution unit behind the reservation
// station. One operation in flight; result broadcast as a one-cycle pulse.
// Optional feature macro: RS_EX_FAST_MUL_EN selects a single-cycle registered
// multiplier; when undefined an iterative shift-add multiplier is used.
// Division is always a radix-2 restoring divider, one quotient bit per cycle.
module rs_ex_muldiv #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rdy,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [DATA_W-1:0] in_v1,
  input  logic [DATA_W-1:0] in_v2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]    CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DATA_W - 1);
  localparam logic [DATA_W-1:0]   ZERO_W   = {DATA_W{1'b0}};
  localparam logic [2*DATA_W-1:0] ZERO_2W  = {(2*DATA_W){1'b0}};
  localparam logic [DATA_W-1:0]   ALL_ONES = {DATA_W{1'b1}};
  localparam logic [DATA_W-1:0]   MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;          // tag of the op in flight
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;          // product accumulator / partial remainder
  logic [2*DATA_W-1:0] a_q, a_d;              // shifted multiplicand / dividend-quotient
  logic [DATA_W-1:0]   b_q, b_d;              // shifted multiplier / divisor
  logic                neg_q, neg_d;          // negate product or quotient
  logic                rneg_q, rneg_d;        // negate remainder
  logic [DATA_W-1:0]   out_result_q, out_result_d;
  logic [TAG_W-1:0]    out_tag_q, out_tag_d;

  // Conditional two's-complement negate, operand width.
  function automatic logic [DATA_W-1:0] neg_w(input logic [DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // Conditional two's-complement negate, double width.
  function automatic logic [2*DATA_W-1:0] neg_2w(input logic [2*DATA_W-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // MUL returns the low half of the product, the MULH group the high half.
  function automatic logic [DATA_W-1:0] mul_pick(input logic [2:0] op, input logic [2*DATA_W-1:0] p);
    return (op[1:0] == 2'b00) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
  endfunction

  // Operand decode at accept time.
  logic              in_sgn1_s, in_sgn2_s, in_neg1_s, in_neg2_s;
  logic [DATA_W-1:0] in_mag1_s, in_mag2_s;
  logic              in_div_zero_s, in_div_ovf_s;

  assign in_sgn1_s     = in_op[2] ? ~in_op[0] : (in_op[1:0] != 2'b11);
  assign in_sgn2_s     = in_op[2] ? ~in_op[0] : ~in_op[1];
  assign in_neg1_s     = in_sgn1_s & in_v1[DATA_W-1];
  assign in_neg2_s     = in_sgn2_s & in_v2[DATA_W-1];
  assign in_mag1_s     = neg_w(in_v1, in_neg1_s);
  assign in_mag2_s     = neg_w(in_v2, in_neg2_s);
  assign in_div_zero_s = (in_v2 == ZERO_W);
  assign in_div_ovf_s  = ~in_op[0] & (in_v1 == MOST_NEG) & (in_v2 == ALL_ONES);

`ifdef RS_EX_FAST_MUL_EN
  logic [2*DATA_W-1:0] in_prod_s;
  assign in_prod_s = {ZERO_W, in_mag1_s} * {ZERO_W, in_mag2_s};
`endif

  // Datapath step for one multiply or divide iteration.
  logic [2*DATA_W-1:0] mul_sum_s, mul_prod_s;
  logic [DATA_W:0]     div_shift_s, div_diff_s;
  logic                div_qbit_s;
  logic [DATA_W-1:0]   div_rem_s, div_quo_s;

  assign mul_sum_s   = acc_q + (b_q[0] ? a_q : ZERO_2W);
  assign mul_prod_s  = neg_2w(mul_sum_s, neg_q);
  assign div_shift_s = {acc_q[DATA_W-1:0], a_q[DATA_W-1]};
  assign div_diff_s  = div_shift_s - {1'b0, b_q};
  assign div_qbit_s  = ~div_diff_s[DATA_W];
  assign div_rem_s   = div_qbit_s ? div_diff_s[DATA_W-1:0] : div_shift_s[DATA_W-1:0];
  assign div_quo_s   = {a_q[DATA_W-2:0], div_qbit_s};

  assign in_ready   = (state_q == ST_IDLE) & rdy & ~flush;
  assign out_valid  = (state_q == ST_DONE) & rdy;
  assign out_result = out_result_q;
  assign out_tag    = out_tag_q;

  // Next-state and datapath update; everything holds while rdy is low.
  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    tag_d        = tag_q;
    cnt_d        = cnt_q;
    acc_d        = acc_q;
    a_d          = a_q;
    b_d          = b_q;
    neg_d        = neg_q;
    rneg_d       = rneg_q;
    out_result_d = out_result_q;
    out_tag_d    = out_tag_q;
    if (rdy) begin
      if (flush) begin
        state_d = ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (in_valid) begin
              op_d   = in_op;
              tag_d  = in_tag;
              cnt_d  = CNT_ZERO;
              neg_d  = in_neg1_s ^ in_neg2_s;
              rneg_d = in_neg1_s;
              if (in_op[2]) begin
                if (in_div_zero_s) begin
                  out_result_d = in_op[1] ? in_v1 : ALL_ONES;
                  out_tag_d    = in_tag;
                  state_d      = ST_DONE;
                end else if (in_div_ovf_s) begin
                  out_result_d = in_op[1] ? ZERO_W : in_v1;
                  out_tag_d    = in_tag;
                  state_d      = ST_DONE;
                end else begin
                  acc_d   = ZERO_2W;
                  a_d     = {ZERO_W, in_mag1_s};
                  b_d     = in_mag2_s;
                  state_d = ST_DIV;
                end
              end else begin
`ifdef RS_EX_FAST_MUL_EN
                out_result_d = mul_pick(in_op, neg_2w(in_prod_s, in_neg1_s ^ in_neg2_s));
                out_tag_d    = in_tag;
                state_d      = ST_DONE;
`else
                acc_d   = ZERO_2W;
                a_d     = {ZERO_W, in_mag1_s};
                b_d     = in_mag2_s;
                state_d = ST_MUL;
`endif
              end
            end else begin
              state_d = ST_IDLE;
            end
          end
          ST_MUL: begin
            acc_d = mul_sum_s;
            a_d   = {a_q[2*DATA_W-2:0], 1'b0};
            b_d   = {1'b0, b_q[DATA_W-1:1]};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              out_result_d = mul_pick(op_q, mul_prod_s);
              out_tag_d    = tag_q;
              state_d      = ST_DONE;
            end else begin
              state_d = ST_MUL;
            end
          end
          ST_DIV: begin
            acc_d = {ZERO_W, div_rem_s};
            a_d   = {ZERO_W, div_quo_s};
            cnt_d = cnt_q + CNT_ONE;
            if (cnt_q == CNT_LAST) begin
              out_result_d = op_q[1] ? neg_w(div_rem_s, rneg_q) : neg_w(div_quo_s, neg_q);
              out_tag_d    = tag_q;
              state_d      = ST_DONE;
            end else begin
              state_d = ST_DIV;
            end
          end
          ST_DONE: begin
            state_d = ST_IDLE;
          end
          default: begin
            state_d = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      op_q         <= 3'd0;
      tag_q        <= {TAG_W{1'b0}};
      cnt_q        <= CNT_ZERO;
      acc_q        <= ZERO_2W;
      a_q          <= ZERO_2W;
      b_q          <= ZERO_W;
      neg_q        <= 1'b0;
      rneg_q       <= 1'b0;
      out_result_q <= ZERO_W;
      out_tag_q    <= {TAG_W{1'b0}};
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      cnt_q        <= cnt_d;
      acc_q        <= acc_d;
      a_q          <= a_d;
      b_q          <= b_d;
      neg_q        <= neg_d;
      rneg_q       <= rneg_d;
      out_result_q <= out_result_d;
      out_tag_q    <= out_tag_d;
    end
  end

endmodule

// File: tb/tb_rs_ex_muldiv.sv
// Scoreboard bench for rs_ex_muldiv: issued ops push their expected result,
// tag and latency; an independent monitor pops on every out_valid pulse.
module tb_rs_ex_muldiv;

  localparam int W  = 32;
  localparam int TW = 4;
`ifdef RS_EX_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n, rdy, flush, in_valid, in_ready, out_valid;
  logic [2:0]    in_op;
  logic [W-1:0]  in_v1, in_v2, out_result;
  logic [TW-1:0] in_tag, out_tag;

  rs_ex_muldiv #(.DATA_W(W), .TAG_W(TW)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_v1(in_v1), .in_v2(in_v2), .in_tag(in_tag),
    .out_valid(out_valid), .out_result(out_result), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  res;
    logic [TW-1:0] tag;
    int            nom;
    int            acc_cyc;
    int            acc_low;
  } exp_t;

  exp_t sb_q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   low_cnt = 0;
  bit   after_pulse = 1'b0;
  bit   rand_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint s1, s2, u1, u2;
    logic [63:0] p;
    bit ovf;
    s1 = longint'($signed(a));
    s2 = longint'($signed(b));
    u1 = longint'({32'd0, a});
    u2 = longint'({32'd0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p = 64'd0;
    case (op)
      3'd0: begin p = s1 * s2; return p[31:0]; end
      3'd1: begin p = s1 * s2; return p[63:32]; end
      3'd2: begin p = s1 * u2; return p[63:32]; end
      3'd3: begin p = u1 * u2; return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = s1 / s2; return p[31:0];
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        p = u1 / u2; return p[31:0];
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        p = s1 % s2; return p[31:0];
      end
      default: begin
        if (b == 32'd0) return a;
        p = u1 % u2; return p[31:0];
      end
    endcase
  endfunction

  function automatic int nominal(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    if (!op[2]) return MUL_LAT;
    if (b == 32'd0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
  endfunction

  function automatic logic [W-1:0] pick();
    case ($urandom_range(7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(15));
      default: return $urandom;
    endcase
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops the scoreboard on each result pulse and checks it.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      after_pulse = 1'b0;
    end else begin
      if (after_pulse && rdy) begin
        check("pulse_width", {63'd0, out_valid}, 64'd0);
        check("in_ready_after_pulse", {63'd0, in_ready}, {63'd0, !flush});
      end
      after_pulse = 1'b0;
      if (!rdy) low_cnt++;
      if (out_valid) begin
        after_pulse = 1'b1;
        if (sb_q.size() == 0) begin
          check("spurious_out_valid", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("result", {32'd0, out_result}, {32'd0, e.res});
          check("tag", {60'd0, out_tag}, {60'd0, e.tag});
          check("latency", 64'(cyc - e.acc_cyc), 64'(e.nom + low_cnt - e.acc_low));
        end
      end
    end
  end

  // Random rdy stall generator, active only in the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) rdy = ($urandom_range(7) != 0);
    end
  end

  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag);
    exp_t e;
    int guard;
    @(posedge clk);
    #1;
    in_valid = 1'b1; in_op = op; in_v1 = a; in_v2 = b; in_tag = tag;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    if (in_ready) begin
      e.res = ref_res(op, a, b); e.tag = tag; e.nom = nominal(op, a, b);
      e.acc_cyc = cyc; e.acc_low = low_cnt;
      sb_q.push_back(e);
    end else begin
      check("accept_timeout", 64'd0, 64'd1);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (sb_q.size() != 0 && guard < 500) begin
      guard++;
      @(negedge clk);
    end
    if (sb_q.size() != 0) begin
      check("result_timeout", 64'd0, 64'd1);
      sb_q.delete();
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [TW-1:0] tag);
    issue(op, a, b, tag);
    wait_idle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rdy = 1'b1; flush = 1'b0; in_valid = 1'b0;
    in_op = 3'd0; in_v1 = 32'd0; in_v2 = 32'd0; in_tag = 4'd0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("reset_out_valid", {63'd0, out_valid}, 64'd0);
    check("reset_out_result", {32'd0, out_result}, 64'd0);
    check("reset_out_tag", {60'd0, out_tag}, 64'd0);
    check("reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Directed arithmetic and special cases.
    run(3'd1, 32'hFFFF_FFFF, 32'd2, 4'd3);
    run(3'd3, 32'hFFFF_FFFF, 32'd2, 4'd4);
    run(3'd0, 32'hFFFF_FFFF, 32'd2, 4'd5);
    run(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6);
    run(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd7);
    run(3'd6, 32'hFFFF_FFF9, 32'd2, 4'd8);
    run(3'd5, 32'd100, 32'd7, 4'd9);
    run(3'd7, 32'd100, 32'd7, 4'd10);
    run(3'd5, 32'd5, 32'd0, 4'd11);
    run(3'd6, 32'd5, 32'd0, 4'd12);
    run(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 4'd13);
    run(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 4'd14);

    // Flush at cycle 10 of a DIV with a competing in_valid.
    issue(3'd4, 32'd1000, 32'd7, 4'd1);
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1; sb_q.delete();
    in_valid = 1'b1; in_op = 3'd5; in_v1 = 32'd50; in_v2 = 32'd5; in_tag = 4'd2;
    @(negedge clk);
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clk);
    #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("post_flush_in_ready", {63'd0, in_ready}, 64'd1);
    run(3'd5, 32'd9, 32'd3, 4'd15);

    // rdy low 3 cycles mid-DIV and 2 cycles over DONE: pulse at cycle 38.
    issue(3'd4, 32'd1000, 32'hFFFF_FFFD, 4'd7);
    repeat (9) @(posedge clk);
    #1 rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1 rdy = 1'b1;
    repeat (23) @(posedge clk);
    #1 rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1 rdy = 1'b1;
    wait_idle();

    // Reset mid-operation returns outputs to their reset values.
    issue(3'd6, 32'd77, 32'd5, 4'd9);
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("midop_reset_result", {32'd0, out_result}, 64'd0);
    check("midop_reset_tag", {60'd0, out_tag}, 64'd0);
    check("midop_reset_in_ready", {63'd0, in_ready}, 64'd1);

    // Randomized ops with random rdy stalls.
    rand_rdy = 1'b1;
    for (int i = 0; i < 120; i++) begin
      run(3'($urandom_range(7)), pick(), pick(), 4'($urandom_range(15)));
    end
    rand_rdy = 1'b0;
    @(posedge clk);
    #2 rdy = 1'b1;
    repeat (5) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
